// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, port ids and constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;
  localparam logic [1:0] BYTESEL_WORD = 2'b11;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter merging instruction and data ports onto one slave bus
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addr_width = 19,
  parameter bit data_first = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width:1]   i_addr,
  input  logic                  i_access,
  output logic                  i_ack,
  output logic [15:0]           i_data_in,
  input  logic [addr_width:1]   d_addr,
  input  logic [15:0]           d_data_out,
  input  logic                  d_access,
  output logic                  d_ack,
  input  logic                  d_wr_en,
  input  logic [1:0]            d_bytesel,
  input  logic                  d_lock,
  output logic [15:0]           d_data_in,
  output logic [addr_width:1]   q_addr,
  output logic [15:0]           q_data_out,
  output logic                  q_access,
  input  logic                  q_ack,
  output logic                  q_wr_en,
  output logic [1:0]            q_bytesel,
  input  logic [15:0]           q_data_in
);
  arb_state_t state, state_nxt;
  port_t      last_grant;
  logic       locked;
  logic       grant_i, grant_d, fwd_ack;
  // state register plus lock and fairness history, updated on each completion
  always_ff @(posedge clk)
    if (reset) begin
      state      <= ARB_IDLE;
      locked     <= 1'b0;
      last_grant <= data_first ? PORT_I : PORT_D;
    end else begin
      state <= state_nxt;
      if (q_ack && state != ARB_IDLE) begin
        locked     <= grant_d && d_lock;
        last_grant <= grant_d ? PORT_D : PORT_I;
      end
    end
  // next state: lock reserves the bus for data, ties alternate, grants always return to idle
  always_comb begin
    state_nxt = state;
    if (state == ARB_IDLE)
      state_nxt = locked                 ? (d_access ? ARB_GRANT_D : ARB_IDLE)
                : (i_access && d_access) ? (last_grant == PORT_D ? ARB_GRANT_I : ARB_GRANT_D)
                : d_access               ? ARB_GRANT_D
                : i_access               ? ARB_GRANT_I
                :                          ARB_IDLE;
    else if (q_ack)
      state_nxt = ARB_IDLE;
  end
  assign grant_i    = state == ARB_GRANT_I;
  assign grant_d    = state == ARB_GRANT_D;
  assign fwd_ack    = q_ack && !reset;
  assign q_access   = grant_i || grant_d;
  assign q_addr     = grant_d ? d_addr : grant_i ? i_addr : '0;
  assign q_data_out = grant_d ? d_data_out : '0;
  assign q_wr_en    = grant_d && d_wr_en;
  assign q_bytesel  = grant_d ? d_bytesel : grant_i ? BYTESEL_WORD : 2'b00;
  assign i_ack      = grant_i && fwd_ack;
  assign d_ack      = grant_d && fwd_ack;
  assign i_data_in  = i_ack ? q_data_in : '0;
  assign d_data_in  = d_ack ? q_data_in : '0;
endmodule
